// File: rtl/note_player_pkg.sv
`default_nettype none
// ============================================================================
// Module      : note_player_pkg
// Description : Shared definitions for the note player controller.
//               Holds the state width and the fixed one-hot-style state codes
//               (RESET is all zeros, the four operating states are one-hot).
// Revision    : 1.0 - initial release
// ============================================================================
package note_player_pkg;

    localparam int c_STATE_W = 4;

    typedef enum logic [c_STATE_W-1:0] {
        ST_RESET     = 4'b0000,
        ST_LOAD_HIGH = 4'b1000,
        ST_WAIT_HIGH = 4'b0100,
        ST_LOAD_LOW  = 4'b0010,
        ST_WAIT_LOW  = 4'b0001
    } state_t;

endpackage
`default_nettype wire

// File: rtl/note_player_ctrl_state_reg.sv
`default_nettype none
// ============================================================================
// Module      : note_player_ctrl_state_reg
// Description : Plain state register for the note player FSM with a
//               synchronous active-high reset to a configurable value.
// Ports       : clk  - system clock
//               rst  - synchronous active-high reset
//               i_d  - next-state value
//               o_q  - registered state value
// Revision    : 1.0 - initial release
// ============================================================================
module note_player_ctrl_state_reg #(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= RESET_VAL;
        end else begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/note_player_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : note_player_ctrl
// Description : Moore FSM that generates a square-wave note. Each half-period
//               starts with a LOAD state that pulses count_load to reload the
//               external down-counter, then a WAIT state that holds until the
//               counter reports count_done.
// Ports       : clk        - system clock, rising-edge active
//               rst        - synchronous active-high reset
//               state      - current state encoding (registered)
//               note       - square-wave output, 1 during the high half
//               count_load - half-period counter load strobe
//               count_done - half-period counter expiry (used in WAIT states)
// Config      : NOTE_PLAYER_CTRL_ASSERT_EN - when defined, compiles in
//               simulation-only consistency checks on state and outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module note_player_ctrl
    import note_player_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    output logic [c_STATE_W-1:0] state,
    output logic                 note,
    output logic                 count_load,
    input  logic                 count_done
);

    logic [c_STATE_W-1:0] r_state;
    logic [c_STATE_W-1:0] w_next_state;

    note_player_ctrl_state_reg #(
        .WIDTH     (c_STATE_W),
        .RESET_VAL (ST_RESET)
    ) u_state_reg (
        .clk (clk),
        .rst (rst),
        .i_d (w_next_state),
        .o_q (r_state)
    );

    // Next-state logic. count_done is only looked at in the WAIT states, so
    // an unknown value on it cannot disturb RESET or LOAD transitions. Any
    // code outside the five legal ones falls back to RESET.
    always_comb begin
        w_next_state = ST_RESET;
        case (r_state)
            ST_RESET:     w_next_state = ST_LOAD_HIGH;
            ST_LOAD_HIGH: w_next_state = ST_WAIT_HIGH;
            ST_WAIT_HIGH: w_next_state = count_done ? ST_LOAD_LOW : ST_WAIT_HIGH;
            ST_LOAD_LOW:  w_next_state = ST_WAIT_LOW;
            ST_WAIT_LOW:  w_next_state = count_done ? ST_LOAD_HIGH : ST_WAIT_LOW;
            default:      w_next_state = ST_RESET;
        endcase
    end

    // Moore outputs, decoded from the registered state only.
    always_comb begin
        note       = 1'b0;
        count_load = 1'b0;
        case (r_state)
            ST_LOAD_HIGH: begin
                note       = 1'b1;
                count_load = 1'b1;
            end
            ST_WAIT_HIGH: begin
                note       = 1'b1;
            end
            ST_LOAD_LOW: begin
                count_load = 1'b1;
            end
            default: begin
                note       = 1'b0;
                count_load = 1'b0;
            end
        endcase
    end

    assign state = r_state;

`ifdef NOTE_PLAYER_CTRL_ASSERT_EN
    always @(posedge clk) begin
        if (!rst) begin
            if (!(r_state inside {ST_RESET, ST_LOAD_HIGH, ST_WAIT_HIGH,
                                  ST_LOAD_LOW, ST_WAIT_LOW})) begin
                $error("note_player_ctrl: illegal state %b", r_state);
            end
            if ($isunknown({note, count_load})) begin
                $error("note_player_ctrl: unknown output in state %b", r_state);
            end
            if (count_load && !(r_state == ST_LOAD_HIGH || r_state == ST_LOAD_LOW)) begin
                $error("note_player_ctrl: count_load outside LOAD in state %b", r_state);
            end
        end
    end
`else
    // Checks not compiled in; functional behaviour is unchanged.
`endif

endmodule
`default_nettype wire

// File: tb/tb_note_player_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_note_player_ctrl
// Description : Self-checking bench for note_player_ctrl: table of directed
//               vectors, a full two-period note pattern, and randomized
//               rst/count_done traffic against a phase-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_note_player_ctrl;

    logic       clk;
    logic       rst;
    logic [3:0] state;
    logic       note;
    logic       count_load;
    logic       count_done;

    int n_cmp;
    int n_fail;

    note_player_ctrl u_dut (
        .clk        (clk),
        .rst        (rst),
        .state      (state),
        .note       (note),
        .count_load (count_load),
        .count_done (count_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       done;
        logic [3:0] st;
        logic       note;
        logic       load;
    } vec_t;

    vec_t vecs[$];

    // Apply inputs, let one rising edge happen, sample 1 time unit later.
    task automatic step(input logic r, input logic d);
        rst        = r;
        count_done = d;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [3:0] st_e,
                         input logic n_e, input logic l_e);
        n_cmp++;
        if ({state, note, count_load} !== {st_e, n_e, l_e}) begin
            n_fail++;
            $display("FAIL %s: got state=%b note=%b load=%b, want state=%b note=%b load=%b",
                     nm, state, note, count_load, st_e, n_e, l_e);
        end
    endtask

    // Reference model kept as a phase description: in reset, which half of
    // the waveform we are in, and whether this is the first (load) cycle.
    bit m_in_reset;
    bit m_high;
    bit m_loading;

    function automatic logic [3:0] model_state();
        if (m_in_reset) return 4'b0000;
        return {m_high & m_loading, m_high & ~m_loading,
                ~m_high & m_loading, ~m_high & ~m_loading};
    endfunction

    task automatic model_advance(input bit r, input bit d);
        if (r) begin
            m_in_reset = 1'b1;
        end else if (m_in_reset) begin
            m_in_reset = 1'b0;
            m_high     = 1'b1;
            m_loading  = 1'b1;
        end else if (m_loading) begin
            m_loading = 1'b0;
        end else if (d) begin
            m_high    = ~m_high;
            m_loading = 1'b1;
        end
    endtask

    initial begin
        n_cmp      = 0;
        n_fail     = 0;
        rst        = 1'b1;
        count_done = 1'b0;

        // {rst, done, expected state after edge, note, load}
        vecs.push_back('{1'b1, 1'b0, 4'b0000, 1'b0, 1'b0}); // reset
        vecs.push_back('{1'b0, 1'b0, 4'b1000, 1'b1, 1'b1}); // first high
        vecs.push_back('{1'b0, 1'b0, 4'b0100, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 4'b0100, 1'b1, 1'b0}); // hold
        vecs.push_back('{1'b0, 1'b1, 4'b0010, 1'b0, 1'b1}); // done -> low
        vecs.push_back('{1'b0, 1'b0, 4'b0001, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 4'b0001, 1'b0, 1'b0}); // hold
        vecs.push_back('{1'b0, 1'b1, 4'b1000, 1'b1, 1'b1}); // done -> high
        vecs.push_back('{1'b0, 1'b1, 4'b0100, 1'b1, 1'b0}); // done ignored in LOAD
        vecs.push_back('{1'b0, 1'b1, 4'b0010, 1'b0, 1'b1}); // 4-cycle loop
        vecs.push_back('{1'b0, 1'b1, 4'b0001, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 4'b1000, 1'b1, 1'b1});
        vecs.push_back('{1'b1, 1'b1, 4'b0000, 1'b0, 1'b0}); // reset beats done
        vecs.push_back('{1'b0, 1'b1, 4'b1000, 1'b1, 1'b1}); // done ignored in RESET
        vecs.push_back('{1'b0, 1'b0, 4'b0100, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 4'b0000, 1'b0, 1'b0}); // reset in WAIT_HIGH
        vecs.push_back('{1'b0, 1'b0, 4'b1000, 1'b1, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 4'b0100, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 4'b0010, 1'b0, 1'b1});
        vecs.push_back('{1'b1, 1'b0, 4'b0000, 1'b0, 1'b0}); // reset in LOAD_LOW
        vecs.push_back('{1'b0, 1'b1, 4'b1000, 1'b1, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 4'b0100, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 4'b0010, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 4'b0001, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 4'b0000, 1'b0, 1'b0}); // reset in WAIT_LOW
        vecs.push_back('{1'b0, 1'b0, 4'b1000, 1'b1, 1'b1}); // recovery

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].done);
            check($sformatf("vec%0d", i), vecs[i].st, vecs[i].note, vecs[i].load);
        end

        // Full cycle: two periods, each half = LOAD + 3 waits + a wait with done.
        begin
            logic [9:0] pattern;
            logic [3:0] exp_st;
            pattern = 10'b11111_00000;
            step(1'b1, 1'b0);
            step(1'b0, 1'b0);
            for (int p = 0; p < 2; p++) begin
                for (int k = 0; k < 10; k++) begin
                    if (k == 0)      exp_st = 4'b1000;
                    else if (k < 5)  exp_st = 4'b0100;
                    else if (k == 5) exp_st = 4'b0010;
                    else             exp_st = 4'b0001;
                    check($sformatf("full p%0d k%0d", p, k), exp_st,
                          pattern[9-k], (k % 5) == 0);
                    step(1'b0, (k % 5) == 4);
                end
            end
        end

        // Randomized traffic against the phase model.
        step(1'b1, 1'b0);
        m_in_reset = 1'b1;
        m_high     = 1'b0;
        m_loading  = 1'b0;
        check("rand reset", model_state(), 1'b0, 1'b0);
        for (int i = 0; i < 400; i++) begin
            bit r;
            bit d;
            r = ($urandom_range(0, 19) == 0);
            d = $urandom_range(0, 1);
            model_advance(r, d);
            step(r, d);
            check($sformatf("rand%0d", i), model_state(),
                  !m_in_reset && m_high, !m_in_reset && m_loading);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
